video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Pixel-clock-domain video timing generator that sits directly downstream of the HDMI PLL. It waits for the PLL lock indication to be stable, then produces the raster timing that the TMDS encoder/serializer stage consumes: horizontal/vertical sync, data enable, and pixel coordinates. Default parameters give 1920x1080p60 at a 148.5 MHz pixel clock. An optional built-in colour-bar source supplies RGB for bring-up.

## Interface

Parameters:
- `H_ACTIVE`, 1920, active pixels per line
- `H_FP`, 88, horizontal front porch in pixels
- `H_SYNC`, 44, hsync width in pixels
- `H_BP`, 148, horizontal back porch in pixels
- `V_ACTIVE`, 1080, active lines
- `V_FP`, 4, vertical front porch in lines
- `V_SYNC`, 5, vsync width in lines
- `V_BP`, 36, vertical back porch in lines
- `HS_POL`, 1, hsync active level
- `VS_POL`, 1, vsync active level
- `LOCK_WAIT`, 1024, consecutive locked cycles required before raster start (≥1)
- Constraint: H_TOTAL = sum of the H_* values ≤ 4096; V_TOTAL likewise ≤ 4096; `H_ACTIVE` is divisible by 8.

Ports:
- `clk` in 1: pixel clock, PLL clkout0
- `rst` in 1: synchronous, active-high reset
- `pll_lock` in 1: PLL lock, asynchronous to `clk`
- `running` out 1: high in RUN state
- `hs` out 1: horizontal sync
- `vs` out 1: vertical sync
- `de` out 1: data enable, active video
- `x` out 12: pixel column, meaningful while `de`
- `y` out 12: pixel row, meaningful while `de`
- `frame_start` out 1: one-cycle pulse coincident with pixel (0,0)
- `r`, `g`, `b` out 8 each: colour-bar RGB, present only with `VTG_COLORBAR_EN`

## Operation

- `pll_lock` passes through a 2-flop synchronizer; `lock_s` denotes the synchronized level.
- FSM states:
  - WAIT_LOCK: settle counter = 0. Go to SETTLE when `lock_s`=1.
  - SETTLE: increment settle counter each cycle while `lock_s`=1. On `lock_s`=0, return to WAIT_LOCK and clear the counter. When the counter reaches `LOCK_WAIT`-1 with `lock_s`=1, go to RUN with h_cnt=v_cnt=0.
  - RUN: raster counters advance. On `lock_s`=0, go to WAIT_LOCK on the next edge. Outputs are forced inactive that same edge, mid-line or mid-frame, and no partial frame continues.
- Raster counters:
  - h_cnt runs 0..H_TOTAL-1, then wraps to 0.
  - v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1, then wraps to 0.
  - Both are held at 0 outside RUN.
- Decode from the counters (registered to outputs):
  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hs active when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC
  - vs active when V_ACTIVE+V_FP ≤ v_cnt < V_ACTIVE+V_FP+V_SYNC. vs changes only at h_cnt = 0.
  - x = h_cnt, y = v_cnt when de; otherwise both are 0.
  - frame_start = (h_cnt == 0 && v_cnt == 0) in RUN.
- Sync polarity: active level = `HS_POL`/`VS_POL`; inactive level = the inverse.
- `rst` is synchronous and takes priority over everything, including a mid-frame reset. It returns the block to WAIT_LOCK and clears the synchronizer, settle counter and raster counters.

## Timing

- Reset/idle values of all outputs: `running`=0, `de`=0, `hs`=~HS_POL, `vs`=~VS_POL, `x`=`y`=0, `frame_start`=0, `r`=`g`=`b`=0.
- Lock latency:
  - `pll_lock` rising to SETTLE entry: 3 edges (2 synchronizer edges + 1 FSM edge).
  - SETTLE to RUN: `LOCK_WAIT` edges.
- `running` rises on the RUN-entry edge.
- First `de`=1 and `frame_start`=1 appear 1 cycle after RUN entry, because outputs are registered from the counters.
- All raster outputs (`hs`, `vs`, `de`, `x`, `y`, `frame_start`, `r`/`g`/`b`) are mutually aligned in the same cycle.
- Lock loss in RUN: `running`=0 and outputs go inactive 3 edges after `pll_lock` falls.

## Configuration

- `VTG_COLORBAR_EN` defined:
  - Ports `r`, `g`, `b` exist, registered and aligned with `de`.
  - Bar index = x / (H_ACTIVE/8), computed from h_cnt.
  - Bars 0..7 in order: white FF/FF/FF, yellow FF/FF/00, cyan 00/FF/FF, green 00/FF/00, magenta FF/00/FF, red FF/00/00, blue 00/00/FF, black 00/00/00.
  - RGB = 0 when `de`=0.
- `VTG_COLORBAR_EN` undefined: `r`, `g`, `b` ports and the bar logic are absent. Timing behaviour is identical.

## Test plan

- Reset and lock: hold `rst`=1 with `pll_lock`=1, then release. Check `running` rises exactly 3+1024 edges later and the first `frame_start`/`de` follows one cycle after that. All outputs hold reset values until then.
- Lock glitch during SETTLE: drop `pll_lock` for 2 cycles at settle count 500. Check the count restarts and RUN entry is 1024+3 edges after lock re-rises.
- Line timing at defaults: `de` high 1920 cycles per line. `hs` rises at column 2008 (1920+88) for 44 cycles. Line period is 2200.
- Frame timing: `vs` high for lines 1084..1088, changing only at h=0. `frame_start` period is 2200*1125 = 2,475,000 cycles. `de` never high on lines ≥1080.
- Lock loss mid-frame: drop `pll_lock` at line 500, column 100. Check outputs go inactive 3 edges later. After re-lock, the raster restarts at (0,0).
- Colour bars (`VTG_COLORBAR_EN` defined): check x=239 gives FF/FF/FF, x=240 gives FF/FF/00, x=1679 gives 00/00/FF, x=1680 gives 00/00/00, and blanking gives 0/0/0.

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen: pixel-clock raster timing generator (hs/vs/de/x/y/frame_start)
// gated by a debounced, synchronized PLL lock. Defaults give 1920x1080p60.
// Optional colour-bar RGB source is enabled by defining VTG_COLORBAR_EN.
module video_timing_gen #(
   parameter int unsigned H_ACTIVE  = 1920,
   parameter int unsigned H_FP      = 88,
   parameter int unsigned H_SYNC    = 44,
   parameter int unsigned H_BP      = 148,
   parameter int unsigned V_ACTIVE  = 1080,
   parameter int unsigned V_FP      = 4,
   parameter int unsigned V_SYNC    = 5,
   parameter int unsigned V_BP      = 36,
   parameter bit          HS_POL    = 1'b1,
   parameter bit          VS_POL    = 1'b1,
   parameter int unsigned LOCK_WAIT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pll_lock,
   output logic        running,
   output logic        hs,
   output logic        vs,
   output logic        de,
   output logic [11:0] x,
   output logic [11:0] y,
   output logic        frame_start
`ifdef VTG_COLORBAR_EN
   ,
   output logic [7:0]  r,
   output logic [7:0]  g,
   output logic [7:0]  b
`endif
);

   localparam int unsigned CW      = 12;
   localparam int unsigned DW      = CW + 1;
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned SW      = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   // Decode thresholds carry one extra bit so a sync ending exactly at 4096 still compares correctly
   localparam logic [DW-1:0] H_ACT  = DW'(H_ACTIVE);
   localparam logic [DW-1:0] H_SBEG = DW'(H_ACTIVE + H_FP);
   localparam logic [DW-1:0] H_SEND = DW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [DW-1:0] V_ACT  = DW'(V_ACTIVE);
   localparam logic [DW-1:0] V_SBEG = DW'(V_ACTIVE + V_FP);
   localparam logic [DW-1:0] V_SEND = DW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_WAIT - 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      SETTLE    = 2'd1,
      RUN       = 2'd2
   } state_t;

   state_t         state, state_nx;
   logic           lock_m, lock_s;
   logic [SW-1:0]  settle_cnt, settle_nx;
   logic [CW-1:0]  h_cnt, h_nx, v_cnt, v_nx;
   logic           run_c;
   logic           de_c, hs_act_c, vs_act_c, fs_c;
   logic [DW-1:0]  h_ext_c, v_ext_c;

   // Two-flop synchronizer for the asynchronous PLL lock
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         lock_m <= pll_lock;
         lock_s <= lock_m;
      end
   end

   // State, settle counter and raster counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= WAIT_LOCK;
         settle_cnt <= '0;
         h_cnt      <= '0;
         v_cnt      <= '0;
      end else begin
         state      <= state_nx;
         settle_cnt <= settle_nx;
         h_cnt      <= h_nx;
         v_cnt      <= v_nx;
      end
   end

   // Next state, settle count and raster advance; counters sit at 0 outside RUN
   always_comb begin
      state_nx  = state;
      settle_nx = '0;
      h_nx      = '0;
      v_nx      = '0;
      run_c     = 1'b0;
      unique case (state)
         WAIT_LOCK: begin
            if (lock_s) state_nx = SETTLE;
         end
         SETTLE: begin
            if (!lock_s)                        state_nx = WAIT_LOCK;
            else if (settle_cnt == SETTLE_LAST) state_nx = RUN;
            else                                settle_nx = settle_cnt + 1'b1;
         end
         RUN: begin
            if (!lock_s) begin
               state_nx = WAIT_LOCK;
            end else begin
               run_c = 1'b1;
               if (h_cnt == H_LAST) begin
                  h_nx = '0;
                  v_nx = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
               end else begin
                  h_nx = h_cnt + 1'b1;
                  v_nx = v_cnt;
               end
            end
         end
         default: state_nx = WAIT_LOCK;
      endcase
   end

   // Raster decode from the current counter values
   always_comb begin
      h_ext_c  = DW'(h_cnt);
      v_ext_c  = DW'(v_cnt);
      de_c     = (h_ext_c < H_ACT) && (v_ext_c < V_ACT);
      hs_act_c = (h_ext_c >= H_SBEG) && (h_ext_c < H_SEND);
      vs_act_c = (v_ext_c >= V_SBEG) && (v_ext_c < V_SEND);
      fs_c     = (h_cnt == '0) && (v_cnt == '0);
   end

`ifdef VTG_COLORBAR_EN
   localparam logic [CW-1:0] BAR_W = CW'(H_ACTIVE / 8);
   logic [2:0] bar_c;

   // Bar index from column; bar order W,Y,C,G,M,R,B,K maps R/G/B to ~bar[1]/~bar[2]/~bar[0]
   always_comb begin
      bar_c = 3'(h_cnt / BAR_W);
   end
`endif

   // Registered outputs; forced idle whenever the raster is not advancing
   always_ff @(posedge clk) begin
      if (rst) running <= 1'b0;
      else     running <= (state_nx == RUN);

      if (rst || !run_c) begin
         hs          <= ~HS_POL;
         vs          <= ~VS_POL;
         de          <= 1'b0;
         x           <= '0;
         y           <= '0;
         frame_start <= 1'b0;
`ifdef VTG_COLORBAR_EN
         r           <= '0;
         g           <= '0;
         b           <= '0;
`endif
      end else begin
         hs          <= hs_act_c ? HS_POL : ~HS_POL;
         vs          <= vs_act_c ? VS_POL : ~VS_POL;
         de          <= de_c;
         x           <= de_c ? h_cnt : '0;
         y           <= de_c ? v_cnt : '0;
         frame_start <= fs_c;
`ifdef VTG_COLORBAR_EN
         r           <= de_c ? {8{~bar_c[1]}} : 8'h00;
         g           <= de_c ? {8{~bar_c[2]}} : 8'h00;
         b           <= de_c ? {8{~bar_c[0]}} : 8'h00;
`endif
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen using a reduced raster so whole frames fit in a short run.
module tb_video_timing_gen;

   localparam int HA = 16, HF = 4, HSW = 3, HB = 5;
   localparam int VA = 6,  VF = 2, VSW = 2, VB = 3;
   localparam int HT = HA + HF + HSW + HB;   // 28
   localparam int VT = VA + VF + VSW + VB;   // 13
   localparam int FR = HT * VT;              // 364
   localparam int LW = 20;
   localparam bit HSP = 1'b1;
   localparam bit VSP = 1'b0;
   localparam int OW = 53;

   typedef logic [OW-1:0] obs_t;

   logic        clk = 1'b0;
   logic        rst, pll_lock;
   logic        running, hs, vs, de, frame_start;
   logic [11:0] x, y;
`ifdef VTG_COLORBAR_EN
   logic [7:0]  r, g, b;
`endif

   obs_t exp_q[$];
   obs_t got, expv;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   video_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
      .HS_POL(HSP), .VS_POL(VSP), .LOCK_WAIT(LW)
   ) dut (
      .clk(clk), .rst(rst), .pll_lock(pll_lock),
      .running(running), .hs(hs), .vs(vs), .de(de),
      .x(x), .y(y), .frame_start(frame_start)
`ifdef VTG_COLORBAR_EN
      , .r(r), .g(g), .b(b)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic obs_t pack_obs(logic run, logic h_s, logic v_s, logic d,
                                     logic [11:0] xx, logic [11:0] yy, logic f, logic [23:0] rgb);
      return {run, h_s, v_s, d, xx, yy, f, rgb};
   endfunction

   function automatic obs_t obs_now();
      logic [23:0] rgb;
      rgb = 24'h0;
`ifdef VTG_COLORBAR_EN
      rgb = {r, g, b};
`endif
      return pack_obs(running, hs, vs, de, x, y, frame_start, rgb);
   endfunction

   function automatic obs_t idle_obs(logic run);
      return pack_obs(run, ~HSP, ~VSP, 1'b0, 12'd0, 12'd0, 1'b0, 24'h0);
   endfunction

`ifdef VTG_COLORBAR_EN
   function automatic logic [23:0] bar_rgb(int i);
      case (i)
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction
`endif

   // Expected outputs k cycles after the first counter position (0,0)
   function automatic obs_t run_obs(int k);
      int h, v;
      logic d, hsa, vsa;
      logic [23:0] rgb;
      h = k % HT;
      v = (k / HT) % VT;
      d = (h < HA) && (v < VA);
      hsa = (h >= HA + HF) && (h < HA + HF + HSW);
      vsa = (v >= VA + VF) && (v < VA + VF + VSW);
      rgb = 24'h0;
`ifdef VTG_COLORBAR_EN
      if (d) rgb = bar_rgb(h / (HA / 8));
`endif
      return pack_obs(1'b1, hsa ? HSP : ~HSP, vsa ? VSP : ~VSP, d,
                      d ? 12'(h) : 12'd0, d ? 12'(v) : 12'd0, (h == 0) && (v == 0), rgb);
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      pll_lock = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(idle_obs(1'b0));
         tick();
         expv = exp_q.pop_front(); got = obs_now(); n_cmp++;
         if (got !== expv) begin n_bad++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, got, expv); end
      end
      rst = 1'b0;
      for (int n = 1; n <= 3 + LW; n++) begin
         exp_q.push_back(idle_obs(n == 3 + LW));
         tick();
         expv = exp_q.pop_front(); got = obs_now(); n_cmp++;
         if (got !== expv) begin n_bad++; $display("FAIL lock_latency edge=%0d got=%h exp=%h", n, got, expv); end
      end
   endtask

   task automatic test_raster();
      for (int k = 0; k < 2 * FR + 10; k++) begin
         exp_q.push_back(run_obs(k));
         tick();
         expv = exp_q.pop_front(); got = obs_now(); n_cmp++;
         if (got !== expv) begin n_bad++; $display("FAIL raster k=%0d got=%h exp=%h", k, got, expv); end
      end
   endtask

   task automatic test_frame_stats();
      int w, n_de, n_hs, n_vs, n_fs, n_de_bad;
      w = 0;
      while (!frame_start && w < 2 * FR) begin tick(); w++; end
      n_cmp++;
      if (!frame_start) begin
         n_bad++; $display("FAIL frame_start_wait got=0 exp=1 after %0d cycles", w);
      end
      n_de = 0; n_hs = 0; n_vs = 0; n_fs = 0; n_de_bad = 0;
      for (int i = 0; i < FR; i++) begin
         if (de) n_de++;
         if (de && y >= 12'(VA)) n_de_bad++;
         if (hs == HSP) n_hs++;
         if (vs == VSP) n_vs++;
         if (i > 0 && frame_start) n_fs++;
         tick();
      end
      n_cmp++; if (n_de != HA * VA) begin n_bad++; $display("FAIL de_per_frame got=%0d exp=%0d", n_de, HA * VA); end
      n_cmp++; if (n_hs != HSW * VT) begin n_bad++; $display("FAIL hs_per_frame got=%0d exp=%0d", n_hs, HSW * VT); end
      n_cmp++; if (n_vs != VSW * HT) begin n_bad++; $display("FAIL vs_per_frame got=%0d exp=%0d", n_vs, VSW * HT); end
      n_cmp++; if (n_fs != 0) begin n_bad++; $display("FAIL fs_extra got=%0d exp=0", n_fs); end
      n_cmp++; if (n_de_bad != 0) begin n_bad++; $display("FAIL de_in_vblank got=%0d exp=0", n_de_bad); end
      n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL fs_period got=%b exp=1 at %0d", frame_start, FR); end
   endtask

   task automatic test_lock_loss();
      int w, k0;
      w = 0;
      while (!(de && x == 12'd5 && y == 12'd3) && w < 2 * FR) begin tick(); w++; end
      n_cmp++;
      if (!(de && x == 12'd5 && y == 12'd3)) begin
         n_bad++; $display("FAIL lockloss_wait got x=%0d y=%0d exp x=5 y=3", x, y);
      end
      k0 = 3 * HT + 5;
      pll_lock = 1'b0;
      for (int n = 1; n <= 7; n++) begin
         exp_q.push_back((n < 3) ? run_obs(k0 + n) : idle_obs(1'b0));
         tick();
         expv = exp_q.pop_front(); got = obs_now(); n_cmp++;
         if (got !== expv) begin n_bad++; $display("FAIL lockloss edge=%0d got=%h exp=%h", n, got, expv); end
      end
      pll_lock = 1'b1;
      for (int n = 1; n <= 3 + LW; n++) begin
         exp_q.push_back(idle_obs(n == 3 + LW));
         tick();
         expv = exp_q.pop_front(); got = obs_now(); n_cmp++;
         if (got !== expv) begin n_bad++; $display("FAIL relock edge=%0d got=%h exp=%h", n, got, expv); end
      end
      for (int k = 0; k < HT + 3; k++) begin
         exp_q.push_back(run_obs(k));
         tick();
         expv = exp_q.pop_front(); got = obs_now(); n_cmp++;
         if (got !== expv) begin n_bad++; $display("FAIL relock_raster k=%0d got=%h exp=%h", k, got, expv); end
      end
   endtask

   task automatic test_settle_glitch();
      pll_lock = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      got = obs_now(); n_cmp++;
      if (got !== idle_obs(1'b0)) begin n_bad++; $display("FAIL glitch_idle got=%h exp=%h", got, idle_obs(1'b0)); end
      pll_lock = 1'b1;
      for (int n = 1; n <= 13; n++) begin
         exp_q.push_back(idle_obs(1'b0));
         tick();
         expv = exp_q.pop_front(); got = obs_now(); n_cmp++;
         if (got !== expv) begin n_bad++; $display("FAIL settle_pre edge=%0d got=%h exp=%h", n, got, expv); end
      end
      pll_lock = 1'b0;
      for (int n = 1; n <= 2; n++) begin
         exp_q.push_back(idle_obs(1'b0));
         tick();
         expv = exp_q.pop_front(); got = obs_now(); n_cmp++;
         if (got !== expv) begin n_bad++; $display("FAIL settle_drop edge=%0d got=%h exp=%h", n, got, expv); end
      end
      pll_lock = 1'b1;
      for (int n = 1; n <= 3 + LW + 2; n++) begin
         exp_q.push_back((n <= 3 + LW) ? idle_obs(n == 3 + LW) : run_obs(n - 4 - LW));
         tick();
         expv = exp_q.pop_front(); got = obs_now(); n_cmp++;
         if (got !== expv) begin n_bad++; $display("FAIL settle_restart edge=%0d got=%h exp=%h", n, got, expv); end
      end
   endtask

   task automatic test_midframe_reset();
      int w;
      w = 0;
      while (!(de && y == 12'd2) && w < 2 * FR) begin tick(); w++; end
      rst = 1'b1;
      for (int n = 1; n <= 2; n++) begin
         exp_q.push_back(idle_obs(1'b0));
         tick();
         expv = exp_q.pop_front(); got = obs_now(); n_cmp++;
         if (got !== expv) begin n_bad++; $display("FAIL midframe_rst edge=%0d got=%h exp=%h", n, got, expv); end
      end
      rst = 1'b0;
      for (int n = 1; n <= 3 + LW + 4; n++) begin
         exp_q.push_back((n <= 3 + LW) ? idle_obs(n == 3 + LW) : run_obs(n - 4 - LW));
         tick();
         expv = exp_q.pop_front(); got = obs_now(); n_cmp++;
         if (got !== expv) begin n_bad++; $display("FAIL rst_restart edge=%0d got=%h exp=%h", n, got, expv); end
      end
   endtask

`ifdef VTG_COLORBAR_EN
   task automatic test_colorbar();
      int w;
      logic [35:0] g36;
      w = 0;
      while (!(de && x == 12'd1) && w < 2 * FR) begin tick(); w++; end
      g36 = {x, r, g, b}; n_cmp++;
      if (g36 !== {12'd1, 24'hFFFFFF}) begin n_bad++; $display("FAIL bar_white_edge got=%h exp=%h", g36, {12'd1, 24'hFFFFFF}); end
      tick();
      g36 = {x, r, g, b}; n_cmp++;
      if (g36 !== {12'd2, 24'hFFFF00}) begin n_bad++; $display("FAIL bar_yellow_edge got=%h exp=%h", g36, {12'd2, 24'hFFFF00}); end
      w = 0;
      while (!(de && x == 12'd13) && w < 2 * FR) begin tick(); w++; end
      g36 = {x, r, g, b}; n_cmp++;
      if (g36 !== {12'd13, 24'h0000FF}) begin n_bad++; $display("FAIL bar_blue_edge got=%h exp=%h", g36, {12'd13, 24'h0000FF}); end
      tick();
      g36 = {x, r, g, b}; n_cmp++;
      if (g36 !== {12'd14, 24'h000000}) begin n_bad++; $display("FAIL bar_black_edge got=%h exp=%h", g36, {12'd14, 24'h000000}); end
      w = 0;
      while (de && w < 2 * FR) begin tick(); w++; end
      g36 = {11'd0, de, r, g, b}; n_cmp++;
      if (g36 !== 36'h0) begin n_bad++; $display("FAIL bar_blank got=%h exp=0", g36); end
   endtask
`endif

   initial begin
      test_reset();
      test_raster();
      test_frame_stats();
      test_lock_loss();
      test_settle_glitch();
      test_midframe_reset();
`ifdef VTG_COLORBAR_EN
      test_colorbar();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
